led_sequencer: RTL
==================

# led_sequencer

Parametrised LED step sequencer for the board-level demo designs. On a start request it steps an LED_WIDTH-bit pattern counter up or down between 0 and MAX_COUNT at a programmable rate, then reports completion with a one-cycle done pulse. The step rate comes from a clock-enable tick in the single clk domain, with no derived clocks. The block adds pause, abort, count direction and continuous-repeat capability to the basic go/count/done LED counter FSM. It sits between the debounced button logic and the LED pins.

## Interface
Parameters:
- LED_WIDTH, 4: width of the led output and the step counter.
- TICK_DIV, 1500000: clk cycles per step. Legal values are 1 and above.
- MAX_COUNT, 2**LED_WIDTH-1: end value of the sequence. Legal range is 1 to 2**LED_WIDTH-1.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start request, active-high level; sampled only in IDLE.
- abort  in  1  cancel the sequence; active-high.
- pause  in  1  freeze the sequence while high.
- down  in  1  direction: 0 counts up 0→MAX_COUNT, 1 counts down MAX_COUNT→0. Latched at start.
- repeat_mode  in  1  1 means wrap and continue at the end value; sampled live at each end-of-pass.
- led  out  LED_WIDTH  current step value.
- busy  out  1  high whenever state is not IDLE.
- done_sig  out  1  one-clk pulse at each end-of-pass.

## Operation
- States are IDLE, RUN and HOLD.
- Priority: rst > abort > pause > tick.
- Reset values: state=IDLE, led=0, busy=0, done_sig=0, tick counter=0, latched direction=0.
- Tick counter:
  - Width is $clog2(TICK_DIV), with a minimum of 1.
  - Counts only in RUN while pause=0 and abort=0.
  - Holds its value in HOLD.
  - Cleared on entry to RUN from IDLE.
  - tick = (state==RUN) && !abort && !pause && (tick counter == TICK_DIV-1). On tick the counter returns to 0.
- IDLE:
  - led=0.
  - When go=1: latch down, load led with the start value (0 if up, MAX_COUNT if down), clear the tick counter, and move to RUN.
  - abort and pause are ignored in IDLE.
- RUN:
  - abort moves to IDLE, with led=0 and no done_sig.
  - pause moves to HOLD.
  - On tick with led below the end value (up) or above it (down), led steps by ±1 and the state stays RUN.
  - On tick with led at the end value (MAX_COUNT for up, 0 for down), done_sig=1 for one cycle, then:
    - if repeat_mode=1: led reloads the start value and the state stays RUN.
    - otherwise: led=0 and the state moves to IDLE.
- HOLD:
  - led and the tick counter are frozen.
  - abort moves to IDLE with led=0.
  - pause=0 moves back to RUN, and counting resumes from the frozen tick count.
- go is ignored while busy=1.
- Arithmetic: led never exceeds MAX_COUNT and never passes below 0; no modulo-2**LED_WIDTH wrap can occur.

## Timing
- All outputs are registered.
- busy rises and led loads its start value on the edge after go is sampled in IDLE; call this edge E0.
- Steps occur at edges E0 + k·TICK_DIV, for k = 1, 2, ….
- End-of-pass occurs at edge E0 + (MAX_COUNT+1)·TICK_DIV:
  - done_sig is high for exactly the following clk cycle.
  - busy falls on the same edge (one-shot mode).
- Each clk cycle spent with pause=1 in RUN or HOLD delays all later steps by one cycle.
- If go is held high through done, IDLE lasts one cycle and the restart edge is one cycle after done.
- abort or rst takes effect on the next edge. The next cycle shows led=0 and busy=0, and done_sig never fires for an aborted pass.
- When TICK_DIV=1, tick fires every RUN cycle.

## Test plan
- Up one-shot (LED_WIDTH=4, TICK_DIV=4, MAX_COUNT=15): 1-cycle go pulse → led shows 0,1,…,15, changing every 4 cycles; done_sig pulses once 64 cycles after E0; then led=0 and busy=0.
- Down: down=1 with a go pulse → led shows 15,14,…,0; done_sig at E0+64; toggling down mid-run has no effect.
- Repeat: repeat_mode=1 → done_sig pulses at E0+64 and again at E0+128 while busy stays 1 and led restarts from 0; clearing repeat_mode during the second pass → IDLE after done at E0+128.
- Pause: pause high for 10 cycles while led=5 → led holds at 5 and busy stays 1; done_sig moves to E0+74.
- Abort and reset: abort in HOLD at led=7 → led=0 and busy=0 on the next edge, with no done_sig; rst mid-RUN → all outputs return to reset values on the next edge; abort and rst asserted in IDLE → no effect beyond reset values.
- Fast config (TICK_DIV=1, MAX_COUNT=3): go held high → led shows 0,1,2,3; done_sig 4 cycles after E0; one IDLE cycle, then an automatic restart.

Source files
------------

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - parametrised LED step sequencer with pause, abort, direction and repeat
//
// Steps an LED_WIDTH-bit value between 0 and MAX_COUNT, one step every
// TICK_DIV clk cycles, and pulses done_sig for one cycle at each end-of-pass.
//
// Ports:
//   clk         in   system clock, the only clock
//   rst         in   synchronous active-high reset
//   go          in   start request level, sampled only in IDLE
//   abort       in   cancel the current pass (RUN/HOLD), no done_sig
//   pause       in   freeze led and the tick counter while high
//   down        in   0: count 0 -> MAX_COUNT, 1: MAX_COUNT -> 0; latched at start
//   repeat_mode in   1: reload the start value at end-of-pass and keep running
//   led         out  current step value (registered)
//   busy        out  high whenever the state is not IDLE (registered)
//   done_sig    out  one-cycle pulse at each end-of-pass (registered)

module led_sequencer #(
  parameter int LED_WIDTH = 4,
  parameter int TICK_DIV  = 1500000,
  parameter int MAX_COUNT = 2**LED_WIDTH-1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 abort,
  input  logic                 pause,
  input  logic                 down,
  input  logic                 repeat_mode,
  output logic [LED_WIDTH-1:0] led,
  output logic                 busy,
  output logic                 done_sig
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0]     TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [LED_WIDTH-1:0] LED_MAX   = LED_WIDTH'(MAX_COUNT);
  localparam logic [LED_WIDTH-1:0] LED_ONE   = LED_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [LED_WIDTH-1:0]   led_q, led_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   down_q, down_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   active;
  logic                   at_end;
  logic                   tick;

  // A HOLD cycle with pause already released behaves as a RUN cycle, so only
  // cycles that actually see pause=1 delay the sequence.
  assign active = (state_q != ST_IDLE) && !abort && !pause;
  assign tick   = active && (cnt_q == TICK_LAST);
  assign at_end = down_q ? (led_q == '0) : (led_q == LED_MAX);

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    down_d  = down_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        led_d = '0;
        cnt_d = '0;
        if (go) begin
          down_d  = down;
          led_d   = down ? LED_MAX : '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
          led_d   = '0;
          cnt_d   = '0;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_RUN;
          if (tick) begin
            cnt_d = '0;
            if (at_end) begin
              done_d = 1'b1;
              if (repeat_mode) begin
                led_d = down_q ? LED_MAX : '0;
              end else begin
                led_d   = '0;
                state_d = ST_IDLE;
              end
            end else begin
              led_d = down_q ? (led_q - LED_ONE) : (led_q + LED_ONE);
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        led_d   = '0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      led_q   <= '0;
      cnt_q   <= '0;
      down_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      down_q  <= down_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign done_sig = done_q;

endmodule
